// File: rtl/seg7_scan_display.sv
// Display back-end: signed 6-bit result -> iterative double-dabble BCD ->
// time-multiplexed sign/tens/units on a 4-digit common-anode 7-segment display.
//
// state   | meaning
// IDLE    | waiting for value_valid, busy low
// CONVERT | one double-dabble step per cycle, six steps total
// LOAD    | sign/tens/units copied to display registers in one cycle
module seg7_scan_display #(
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] value,
  input  logic       value_valid,
  output logic       busy,
  output logic [6:0] segm,
  output logic [3:0] transistor
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SCAN_RELOAD = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  localparam logic [2:0] LAST_STEP = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  mag;
  logic [7:0]  bcd;
  logic [7:0]  bcd_adj;
  logic [2:0]  step_cnt;
  logic        neg;
  logic [5:0]  value_abs;

  logic [6:0]  disp3;
  logic [6:0]  disp1;
  logic [6:0]  disp0;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    scan_idx;
  logic [6:0]    glyph_sel;
  logic [3:0]    enable_onehot;

  // Active-low glyph patterns {g,f,e,d,c,b,a}; polarity is applied at the pins.
  function automatic logic [6:0] glyph(input logic [3:0] digit);
    logic [6:0] g;
    g = GLYPH_BLANK;
    case (digit)
      4'd0: g = 7'b1000000;
      4'd1: g = 7'b1111001;
      4'd2: g = 7'b0100100;
      4'd3: g = 7'b0110000;
      4'd4: g = 7'b0011001;
      4'd5: g = 7'b0010010;
      4'd6: g = 7'b0000010;
      4'd7: g = 7'b1111000;
      4'd8: g = 7'b0000000;
      4'd9: g = 7'b0010000;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // -32 maps to 6'b100000, which is +32 read as unsigned, so no extra bit is needed.
  always_comb begin
    value_abs = value;
    if (value[5]) begin
      value_abs = ~value + 6'd1;
    end
  end

  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) begin
      bcd_adj[3:0] = bcd[3:0] + 4'd3;
    end
    if (bcd[7:4] >= 4'd5) begin
      bcd_adj[7:4] = bcd[7:4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      step_cnt <= '0;
      neg      <= 1'b0;
      disp3    <= GLYPH_BLANK;
      disp1    <= GLYPH_BLANK;
      disp0    <= GLYPH_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid) begin
            neg      <= value[5];
            mag      <= value_abs;
            bcd      <= '0;
            step_cnt <= '0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          // Magnitude never exceeds 32, so the tens nibble's MSB is always zero.
          bcd      <= 8'({bcd_adj, mag[5]});
          mag      <= {mag[4:0], 1'b0};
          step_cnt <= step_cnt + 3'd1;
          if (step_cnt == LAST_STEP) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          disp3 <= neg ? GLYPH_DASH : GLYPH_BLANK;
          disp1 <= (bcd[7:4] == 4'd0) ? GLYPH_BLANK : glyph(bcd[7:4]);
          disp0 <= glyph(bcd[3:0]);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Scan timer counts down and advances the digit on terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= SCAN_RELOAD;
      scan_idx <= 2'd0;
    end else if (scan_cnt == '0) begin
      scan_cnt <= SCAN_RELOAD;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt - 1'b1;
    end
  end

  always_comb begin
    glyph_sel = GLYPH_BLANK;
    case (scan_idx)
      2'd0: glyph_sel = disp0;
      2'd1: glyph_sel = disp1;
      2'd2: glyph_sel = GLYPH_BLANK;
      2'd3: glyph_sel = disp3;
      default: glyph_sel = GLYPH_BLANK;
    endcase
  end

  assign enable_onehot = 4'b0001 << scan_idx;

  // Enable and segment pins switch on the same edge; no blanking gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      segm       <= SEG_OFF;
      transistor <= AN_OFF;
    end else begin
      segm       <= (SEG_ACTIVE_LOW != 0) ? glyph_sel : ~glyph_sel;
      transistor <= (AN_ACTIVE_LOW != 0) ? ~enable_onehot : enable_onehot;
    end
  end

endmodule
